// File: rtl/range_bargraph_pkg.sv
// Shared definitions for the range bar-graph display stage.
//   state_t  : link-health states
//   T1..T4   : proximity thresholds in mm (level L lights below T_L)
//   HYST     : extra distance needed before a level is released
//   FILL     : buffer contents after reset
package range_bargraph_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    TRACK = 2'd1,
    STALE = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0] T1   = 8'd200;
  localparam logic [7:0] T2   = 8'd150;
  localparam logic [7:0] T3   = 8'd100;
  localparam logic [7:0] T4   = 8'd50;
  localparam logic [7:0] HYST = 8'd8;
  localparam logic [7:0] FILL = 8'hFF;

  // Level implied by the thresholds alone, ignoring hysteresis.
  function automatic logic [2:0] level_of(input logic [7:0] avg);
    if (avg < T4)      return 3'd4;
    else if (avg < T3) return 3'd3;
    else if (avg < T2) return 3'd2;
    else if (avg < T1) return 3'd1;
    else               return 3'd0;
  endfunction

  // Threshold that guards a given level.
  function automatic logic [7:0] thr_of(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return T1;
      3'd2:    return T2;
      3'd3:    return T3;
      3'd4:    return T4;
      default: return FILL;
    endcase
  endfunction

endpackage

// File: rtl/range_avg4.sv
// Four-sample moving average of range readings.
//   clk, rst : clock, asynchronous active-high reset
//   push     : store data as newest sample (oldest is dropped)
//   data     : sample in mm
//   avg_mm   : truncated mean of the four stored samples, one edge after push
//   upd      : one-cycle pulse while avg_mm shows a freshly pushed sample
module range_avg4
  import range_bargraph_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] data,
  output logic [7:0] avg_mm,
  output logic       upd
);

  logic [7:0] smp [4];
  logic [9:0] sum;
  logic       push_q;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum = sum + 10'(smp[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        smp[i] <= FILL;
      end
      push_q <= 1'b0;
      upd    <= 1'b0;
      avg_mm <= FILL;
    end else begin
      if (push) begin
        smp[0] <= data;
        for (int unsigned i = 1; i < 4; i++) begin
          smp[i] <= smp[i-1];
        end
      end
      push_q <= push;
      upd    <= push_q;
      avg_mm <= sum[9:2];
    end
  end

endmodule

// File: rtl/range_bargraph.sv
// Range bar-graph display: smooths range samples, drives a hysteretic
// proximity bar on D1..D4 and link health on D5, all PWM-dimmed.
//   CLK_12M, RST          : clock, asynchronous active-high reset
//   range_mm/valid/err    : sample, strobe and sensor error flag
//   D1..D4                : bar LEDs (D1 lights first), only while tracking
//   D5                    : solid in TRACK, blinking in WAIT/STALE, off in ERROR
//   avg_mm                : current moving average
//   stale                 : high in WAIT and STALE
module range_bargraph
  import range_bargraph_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 12_000_000,
  parameter int unsigned STALE_MS = 200,
  parameter int unsigned BLINK_HZ = 4,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DUTY     = 8
) (
  input  logic       CLK_12M,
  input  logic       RST,
  input  logic [7:0] range_mm,
  input  logic       range_valid,
  input  logic       range_err,
  output logic       D1,
  output logic       D2,
  output logic       D3,
  output logic       D4,
  output logic       D5,
  output logic [7:0] avg_mm,
  output logic       stale
);

  localparam int unsigned STALE_CYC = (CLK_HZ / 1000) * STALE_MS;
  localparam int unsigned BLINK_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned TW  = (STALE_CYC > 1) ? $clog2(STALE_CYC) : 1;
  localparam int unsigned BW  = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam int unsigned PW1 = PWM_BITS + 1;
  localparam logic [TW-1:0]  TLOAD  = TW'(STALE_CYC - 1);
  localparam logic [BW-1:0]  BLAST  = BW'(BLINK_CYC - 1);
  localparam logic [PW1-1:0] DUTY_V = PW1'(DUTY);

  logic good, bad, expire, avg_upd;
  logic [TW-1:0] tmr;
  logic armed;
  state_t state, st_d1, st_d2;
  logic [2:0] level, level_nxt, tgt;
  logic fall_ok, pwm_on, blink;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BW-1:0] blink_cnt;

  assign good   = range_valid & ~range_err;
  assign bad    = range_valid & range_err;
  assign expire = armed && (tmr == '0);

  range_avg4 u_avg (
    .clk    (CLK_12M),
    .rst    (RST),
    .push   (good),
    .data   (range_mm),
    .avg_mm (avg_mm),
    .upd    (avg_upd)
  );

  // Link FSM with its stale timer; a good sample outranks expiry.
  always_ff @(posedge CLK_12M or posedge RST) begin
    if (RST) begin
      state <= WAIT;
      tmr   <= '0;
      armed <= 1'b0;
      stale <= 1'b1;
    end else begin
      stale <= (state == WAIT) || (state == STALE);
      if (good) begin
        tmr   <= TLOAD;
        armed <= 1'b1;
      end else if (armed) begin
        if (tmr == '0) armed <= 1'b0;
        else           tmr   <= tmr - 1'b1;
      end
      case (state)
        WAIT, STALE: if (good) state <= TRACK;
        TRACK: begin
          if (good)        state <= TRACK;
          else if (bad)    state <= ERROR;
          else if (expire) state <= STALE;
        end
        ERROR: begin
          if (good)        state <= TRACK;
          else if (expire) state <= STALE;
        end
        default: state <= WAIT;
      endcase
    end
  end

  // Rise at once; fall only once the average clears the current threshold
  // by HYST, then settle on whatever level the thresholds imply.
  always_comb begin
    tgt       = level_of(avg_mm);
    fall_ok   = {1'b0, avg_mm} >= ({1'b0, thr_of(level)} + {1'b0, HYST});
    level_nxt = level;
    if (tgt > level)                level_nxt = tgt;
    else if (tgt < level && fall_ok) level_nxt = tgt;
  end

  always_ff @(posedge CLK_12M or posedge RST) begin
    if (RST)          level <= '0;
    else if (avg_upd) level <= level_nxt;
  end

  assign pwm_on = {1'b0, pwm_cnt} < DUTY_V;

  // State is delayed two edges so the LEDs switch state and level together.
  always_ff @(posedge CLK_12M or posedge RST) begin
    if (RST) begin
      st_d1     <= WAIT;
      st_d2     <= WAIT;
      pwm_cnt   <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      D1 <= 1'b0;
      D2 <= 1'b0;
      D3 <= 1'b0;
      D4 <= 1'b0;
      D5 <= 1'b0;
    end else begin
      st_d1   <= state;
      st_d2   <= st_d1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (blink_cnt == BLAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      D1 <= (st_d2 == TRACK) && pwm_on && (level >= 3'd1);
      D2 <= (st_d2 == TRACK) && pwm_on && (level >= 3'd2);
      D3 <= (st_d2 == TRACK) && pwm_on && (level >= 3'd3);
      D4 <= (st_d2 == TRACK) && pwm_on && (level >= 3'd4);
      case (st_d2)
        TRACK:       D5 <= pwm_on;
        WAIT, STALE: D5 <= blink && pwm_on;
        default:     D5 <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_range_bargraph.sv
// Self-checking bench for range_bargraph: fixed vector table, hand-written
// timing corner cases, and randomized sample bursts against a queue model.
module tb_range_bargraph;

  logic       CLK_12M = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] range_mm = '0;
  logic       range_valid = 1'b0;
  logic       range_err = 1'b0;
  logic       D1, D2, D3, D4, D5, stale;
  logic [7:0] avg_mm;
  logic       p_D1, p_D2, p_D3, p_D4, p_D5, p_stale;
  logic [7:0] p_avg;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK_12M = ~CLK_12M;

  range_bargraph #(
    .CLK_HZ(12_000_000), .STALE_MS(1), .BLINK_HZ(1000), .PWM_BITS(4), .DUTY(16)
  ) dut (
    .CLK_12M(CLK_12M), .RST(RST), .range_mm(range_mm), .range_valid(range_valid),
    .range_err(range_err), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5),
    .avg_mm(avg_mm), .stale(stale)
  );

  range_bargraph #(
    .CLK_HZ(12_000_000), .STALE_MS(1), .BLINK_HZ(1000), .PWM_BITS(4), .DUTY(4)
  ) dut_pwm (
    .CLK_12M(CLK_12M), .RST(RST), .range_mm(range_mm), .range_valid(range_valid),
    .range_err(range_err), .D1(p_D1), .D2(p_D2), .D3(p_D3), .D4(p_D4), .D5(p_D5),
    .avg_mm(p_avg), .stale(p_stale)
  );

  typedef struct {
    logic [7:0] mm;
    logic       err;
    logic [7:0] avg;
    logic [3:0] bar;   // {D1,D2,D3,D4}
    logic       d5;
    logic       stl;
  } vec_t;

  vec_t tbl[16];
  vec_t prev;

  // Reference model: last four good samples, abstract state, level.
  int unsigned m_buf[$];
  int unsigned m_level;
  int          m_state;   // 0 wait, 1 track, 2 stale, 3 error
  int unsigned THR[4] = '{200, 150, 100, 50};

  task automatic tick();
    @(posedge CLK_12M);
    @(negedge CLK_12M);
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [7:0] v, input logic e);
    range_mm = v;
    range_valid = 1'b1;
    range_err = e;
    tick();
    range_valid = 1'b0;
    range_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK_12M);
    RST = 1'b1;
    ticks(2);
    RST = 1'b0;
  endtask

  function automatic logic [3:0] bar();
    return {D1, D2, D3, D4};
  endfunction

  function automatic void m_reset();
    m_buf = '{255, 255, 255, 255};
    m_level = 0;
    m_state = 0;
  endfunction

  function automatic int unsigned m_avg();
    int unsigned s = 0;
    foreach (m_buf[i]) s += m_buf[i];
    return s / 4;
  endfunction

  function automatic void m_sample(input int unsigned v, input logic e);
    int unsigned a, tgt;
    if (e) begin
      if (m_state == 1) m_state = 3;
      return;
    end
    m_buf.push_front(v);
    void'(m_buf.pop_back());
    m_state = 1;
    a = m_avg();
    tgt = 0;
    foreach (THR[i]) if (a < THR[i]) tgt++;
    if (tgt > m_level) m_level = tgt;
    else if (tgt < m_level && a >= THR[m_level-1] + 8) m_level = tgt;
  endfunction

  function automatic logic [3:0] m_bar();
    logic [3:0] b = '0;
    if (m_state == 1)
      b = {m_level >= 1, m_level >= 2, m_level >= 3, m_level >= 4};
    return b;
  endfunction

  initial begin
    tbl[0]  = '{8'd40,  1'b0, 8'd201, 4'b0000, 1'b1, 1'b0};
    tbl[1]  = '{8'd40,  1'b0, 8'd147, 4'b1100, 1'b1, 1'b0};
    tbl[2]  = '{8'd40,  1'b0, 8'd93,  4'b1110, 1'b1, 1'b0};
    tbl[3]  = '{8'd40,  1'b0, 8'd40,  4'b1111, 1'b1, 1'b0};
    tbl[4]  = '{8'd88,  1'b0, 8'd52,  4'b1111, 1'b1, 1'b0};
    tbl[5]  = '{8'd64,  1'b0, 8'd58,  4'b1110, 1'b1, 1'b0};
    tbl[6]  = '{8'd4,   1'b0, 8'd49,  4'b1111, 1'b1, 1'b0};
    tbl[7]  = '{8'd0,   1'b1, 8'd49,  4'b0000, 1'b0, 1'b0};
    tbl[8]  = '{8'd120, 1'b0, 8'd69,  4'b1110, 1'b1, 1'b0};
    tbl[9]  = '{8'd120, 1'b0, 8'd77,  4'b1110, 1'b1, 1'b0};
    tbl[10] = '{8'd120, 1'b0, 8'd91,  4'b1110, 1'b1, 1'b0};
    tbl[11] = '{8'd120, 1'b0, 8'd120, 4'b1100, 1'b1, 1'b0};
    tbl[12] = '{8'd194, 1'b0, 8'd138, 4'b1100, 1'b1, 1'b0};
    tbl[13] = '{8'd194, 1'b0, 8'd157, 4'b1100, 1'b1, 1'b0};
    tbl[14] = '{8'd124, 1'b0, 8'd158, 4'b1000, 1'b1, 1'b0};
    tbl[15] = '{8'd0,   1'b1, 8'd158, 4'b0000, 1'b0, 1'b0};

    // Reset state, then WAIT blink timing (half period 6000 cycles).
    @(negedge CLK_12M);
    check("reset_outputs", {bar(), D5, avg_mm, stale}, {4'b0000, 1'b0, 8'hFF, 1'b1});
    RST = 1'b0;
    ticks(6000);
    check("blink_6000", D5, 1'b0);
    tick();
    check("blink_6001", D5, 1'b1);
    ticks(5999);
    check("blink_12000", D5, 1'b1);
    tick();
    check("blink_12001", D5, 1'b0);
    check("wait_outputs", {bar(), avg_mm, stale}, {4'b0000, 8'hFF, 1'b1});

    // Table: at k old avg/stale, at k+2 old bar, at k+3 new outputs.
    prev = '{8'd0, 1'b0, 8'hFF, 4'b0000, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      strobe(tbl[i].mm, tbl[i].err);
      check($sformatf("v%0d_hold_avg", i), avg_mm, prev.avg);
      check($sformatf("v%0d_hold_stale", i), stale, prev.stl);
      ticks(2);
      check($sformatf("v%0d_hold_bar", i), bar(), prev.bar);
      tick();
      check($sformatf("v%0d_avg", i), avg_mm, tbl[i].avg);
      check($sformatf("v%0d_bar", i), bar(), tbl[i].bar);
      check($sformatf("v%0d_d5", i), D5, tbl[i].d5);
      check($sformatf("v%0d_stale", i), stale, tbl[i].stl);
      prev = tbl[i];
    end

    // Back to TRACK at level 1, then PWM duty over two periods.
    strobe(8'd194, 1'b0);   // avg (194+124+194+194)/4 = 176, level 1
    ticks(3);
    begin
      int hi_full, hi_pwm;
      hi_full = 0;
      hi_pwm = 0;
      for (int i = 0; i < 32; i++) begin
        tick();
        if (D1) hi_full++;
        if (p_D1) hi_pwm++;
      end
      check("pwm_duty16_D1", hi_full, 32);
      check("pwm_duty4_D1", hi_pwm, 8);
    end

    // Asynchronous reset while tracking.
    check("pre_reset_D1", D1, 1'b1);
    #2 RST = 1'b1;
    #1 check("async_reset", {bar(), D5, avg_mm, stale}, {4'b0000, 1'b0, 8'hFF, 1'b1});
    @(negedge CLK_12M);
    RST = 1'b0;

    // Stale expiry: 12000 idle cycles after the last good sample.
    for (int i = 0; i < 4; i++) strobe(8'd20, 1'b0);
    ticks(11999);
    check("stale_pre_expiry", {bar(), stale}, {4'b1111, 1'b0});
    tick();
    check("stale_at_expiry_edge", stale, 1'b0);
    tick();
    check("stale_after_expiry", stale, 1'b1);
    ticks(3);
    check("stale_bar_off", bar(), 4'b0000);

    // Good strobe landing on the expiry cycle keeps TRACK.
    strobe(8'd20, 1'b0);
    ticks(11999);
    strobe(8'd20, 1'b0);
    tick();
    check("tie_stale", stale, 1'b0);
    ticks(3);
    check("tie_track", {bar(), D5, stale}, {4'b1111, 1'b1, 1'b0});

    // Randomized bursts against the model.
    do_reset();
    m_reset();
    for (int b = 0; b < 150; b++) begin
      int unsigned n = $urandom_range(1, 3);
      for (int unsigned j = 0; j < n; j++) begin
        int unsigned v = $urandom_range(0, 255);
        logic e = ($urandom_range(0, 5) == 0);
        strobe(v[7:0], e);
        m_sample(v, e);
      end
      ticks(3);
      check($sformatf("rnd%0d_avg", b), avg_mm, m_avg());
      check($sformatf("rnd%0d_bar", b), bar(), m_bar());
      check($sformatf("rnd%0d_stale", b), stale, (m_state == 0 || m_state == 2));
      if (m_state == 1 || m_state == 3)
        check($sformatf("rnd%0d_d5", b), D5, (m_state == 1));
      ticks($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
